// File: rtl/run_pattern_tx_pkg.sv
// Shared definitions for the run-length pattern transmitter.
package run_pattern_tx_pkg;

    // Default width of the length/count fields and counters.
    localparam int CW_DEFAULT = 4;

    // Transmitter FSM state encodings.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/run_pattern_tx_ld_down_counter.sv
// Loadable down-counter. It stops at zero instead of wrapping, and flags the
// final count so the controller can act on the last cycle of a phase.
module ld_down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] ONE = 1;

    logic [CW-1:0] count_reg;

    // Load takes priority over decrement; a zero count holds at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == ONE);

endmodule

// File: rtl/run_pattern_tx.sv
// Serial run-length pattern transmitter: emits bursts of ones separated by
// gaps of zeros on x, with run length, gap length and burst count per request.
module run_pattern_tx
    import run_pattern_tx_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] run_len,
    input  logic [CW-1:0] gap_len,
    input  logic [CW-1:0] bursts,
    output logic          x,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] ONE = 1;

    state_t        state_reg, state_next;
    logic [CW-1:0] run_len_reg, gap_len_reg;
    logic [CW-1:0] gap_load_val;
    logic          latch_fields;

    logic          run_load, run_en, run_last;
    logic [CW-1:0] run_load_val;
    logic          gap_load, gap_en, gap_last;
    logic          burst_load, burst_en, burst_last;
    logic [CW-1:0] run_count, gap_count, burst_count;

    logic          x_reg, busy_reg, done_reg;
    logic          x_next, busy_next, done_next;

    // A zero gap still separates bursts with a single zero.
    assign gap_load_val = (gap_len_reg == '0) ? ONE : gap_len_reg;

    ld_down_counter #(.CW(CW)) u_run_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (run_load),
        .load_val (run_load_val),
        .en       (run_en),
        .count    (run_count),
        .last     (run_last)
    );

    ld_down_counter #(.CW(CW)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .en       (gap_en),
        .count    (gap_count),
        .last     (gap_last)
    );

    // The burst counter itself holds the requested burst count.
    ld_down_counter #(.CW(CW)) u_burst_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (burst_load),
        .load_val (bursts),
        .en       (burst_en),
        .count    (burst_count),
        .last     (burst_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Run and gap lengths are kept for reloading on every burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len_reg <= '0;
            gap_len_reg <= '0;
        end else if (latch_fields) begin
            run_len_reg <= run_len;
            gap_len_reg <= gap_len;
        end
    end

    // Next-state, counter control and output decode of the current state.
    always_comb begin
        state_next   = state_reg;
        latch_fields = 1'b0;
        run_load     = 1'b0;
        run_load_val = run_len_reg;
        run_en       = 1'b0;
        gap_load     = 1'b0;
        gap_en       = 1'b0;
        burst_load   = 1'b0;
        burst_en     = 1'b0;
        x_next       = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    latch_fields = 1'b1;
                    if ((run_len == '0) || (bursts == '0)) begin
                        state_next = DONE;
                    end else begin
                        state_next   = RUN;
                        run_load     = 1'b1;
                        run_load_val = run_len;
                        burst_load   = 1'b1;
                    end
                end
            end
            RUN: begin
                x_next    = 1'b1;
                busy_next = 1'b1;
                run_en    = 1'b1;
                if (run_last) begin
                    state_next = GAP;
                    gap_load   = 1'b1;
                end
            end
            GAP: begin
                busy_next = 1'b1;
                gap_en    = 1'b1;
                if (gap_last) begin
                    burst_en = 1'b1;
                    if (burst_last) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        run_load   = 1'b1;
                    end
                end
            end
            DONE: begin
                busy_next  = 1'b1;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output registers trail the state by one edge, so x is glitch-free and
    // the first one appears after the edge following the start sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg    <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            x_reg    <= x_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    assign x    = x_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_run_pattern_tx.sv
// Scoreboard bench for run_pattern_tx: requests push expected per-cycle
// tokens, a monitor pops and compares one token per busy cycle.
module tb_run_pattern_tx;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] run_len = '0;
    logic [CW-1:0] gap_len = '0;
    logic [CW-1:0] bursts = '0;
    logic          x, busy, done;

    run_pattern_tx #(.CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .run_len (run_len),
        .gap_len (gap_len),
        .bursts  (bursts),
        .x       (x),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic x;
        logic done;
        logic det;
        bit   chk_det;
    } tok_t;

    tok_t exp_q[$];
    int   done_cyc[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ones_run = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: a detector of three or more consecutive ones listens to x,
    // and each busy cycle is matched against the next expected token.
    always @(negedge clk) begin : monitor
        logic det;
        tok_t t;
        if (rst) begin
            det = x && (ones_run >= 2);
            ones_run = x ? ones_run + 1 : 0;
            if (done) done_cyc.push_back(cyc);
            if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    t = exp_q.pop_front();
                    chk("x", x, t.x);
                    chk("done", done, t.done);
                    if (t.chk_det) chk("det", det, t.det);
                end
            end else begin
                chk("idle_x", x, 0);
                chk("idle_done", done, 0);
            end
        end else begin
            ones_run = 0;
        end
    end

    task automatic push_req(input string xs, input string ds, input bit chk_det);
        tok_t t;
        for (int i = 0; i < xs.len(); i++) begin
            t.x       = (xs[i] == 8'h31);
            t.done    = 1'b0;
            t.det     = chk_det ? (ds[i] == 8'h31) : 1'b0;
            t.chk_det = chk_det;
            exp_q.push_back(t);
        end
        t.x = 1'b0; t.done = 1'b1; t.det = 1'b0; t.chk_det = chk_det;
        exp_q.push_back(t);
    endtask

    // Called at posedge+1; returns one time unit after E1.
    task automatic send(input int r, input int g, input int b,
                        input string xs, input string ds, input bit chk_det);
        $display("req run=%0d gap=%0d bursts=%0d", r, g, b);
        push_req(xs, ds, chk_det);
        run_len = CW'(r); gap_len = CW'(g); bursts = CW'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_len = CW'($urandom); gap_len = CW'($urandom); bursts = CW'($urandom);
        chk("lat_e0_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("lat_e1_busy", busy, 1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", (k >= budget), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        string xs;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a burst.
        $display("req run=5 gap=2 bursts=1 (reset on third one)");
        push_req("1111100", "", 1'b0);
        run_len = 4'd5; gap_len = 4'd2; bursts = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_run_x", x, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_x", x, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle_busy", busy, 0);
        end

        // Basic pattern.
        send(3, 2, 2, "1110011100", "", 1'b0);
        drain(100);

        // Zero gap behaves as a one-cycle gap.
        send(2, 0, 3, "110110110", "", 1'b0);
        drain(100);

        // Degenerate requests.
        send(0, 4, 3, "", "", 1'b0);
        drain(100);
        send(4, 1, 0, "", "", 1'b0);
        drain(100);

        // Single one followed by the longest gap.
        send(1, 15, 1, "1000000000000000", "", 1'b0);
        drain(100);

        // A second start during RUN is ignored.
        send(3, 1, 1, "1110", "", 1'b0);
        start = 1'b1; run_len = 4'd7; gap_len = 4'd5; bursts = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(100);

        // start held high: the next request follows the first at L+2 spacing.
        $display("req run=2 gap=1 bursts=1 twice (start held)");
        done_cyc.delete();
        push_req("110", "", 1'b0);
        push_req("110", "", 1'b0);
        run_len = 4'd2; gap_len = 4'd1; bursts = 4'd1;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        drain(100);
        chk("held_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2) chk("held_done_spacing", done_cyc[1] - done_cyc[0], 5);

        // Detector loopback: detector fires on the 3rd and 4th one.
        send(4, 3, 2, "11110001111000", "00110000011000", 1'b1);
        drain(100);

        // Largest request: 15 bursts of 15 ones and 15 zeros.
        xs = "";
        for (int b = 0; b < 15; b++) begin
            for (int i = 0; i < 15; i++) xs = {xs, "1"};
            for (int i = 0; i < 15; i++) xs = {xs, "0"};
        end
        send(15, 15, 15, xs, "", 1'b0);
        drain(600);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
